// File: rtl/rtclock_axi_regs_pkg.sv
// rtclock_axi_regs_pkg
// Shared register map for the rtclock CPU interface: register offsets within
// the 256-byte window, AXI response codes, register reset values, the
// register-select type produced by address decode, and a byte-strobe merge
// helper used by every writable register.
package rtclock_axi_regs_pkg;

  localparam logic [7:0] REG_ID_ADDR          = 8'h00;
  localparam logic [7:0] REG_VERSION_ADDR     = 8'h04;
  localparam logic [7:0] REG_FLIP_ADDR        = 8'h08;
  localparam logic [7:0] REG_SNAP_SEC_LO_ADDR = 8'h10;
  localparam logic [7:0] REG_SNAP_SEC_HI_ADDR = 8'h14;
  localparam logic [7:0] REG_SNAP_NSEC_ADDR   = 8'h18;
  localparam logic [7:0] REG_SET_SEC_LO_ADDR  = 8'h20;
  localparam logic [7:0] REG_SET_SEC_HI_ADDR  = 8'h24;
  localparam logic [7:0] REG_SET_NSEC_ADDR    = 8'h28;
  localparam logic [7:0] REG_CTRL_ADDR        = 8'h2C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] FLIP_RESET     = '0;
  localparam logic [31:0] SET_SEC_RESET  = '0;
  localparam logic [15:0] SET_SECH_RESET = '0;
  localparam logic [29:0] SET_NSEC_RESET = '0;

  typedef enum logic [3:0] {
    SEL_ID,
    SEL_VERSION,
    SEL_FLIP,
    SEL_SNAP_LO,
    SEL_SNAP_HI,
    SEL_SNAP_NSEC,
    SEL_SET_LO,
    SEL_SET_HI,
    SEL_SET_NSEC,
    SEL_CTRL,
    SEL_NONE
  } reg_sel_t;

  // Byte offset within the window to register select; ADDR[1:0] is masked off.
  function automatic reg_sel_t decode_offset(input logic in_window, input logic [7:0] off);
    reg_sel_t sel;
    sel = SEL_NONE;
    if (in_window) begin
      case (off & 8'hFC)
        REG_ID_ADDR:          sel = SEL_ID;
        REG_VERSION_ADDR:     sel = SEL_VERSION;
        REG_FLIP_ADDR:        sel = SEL_FLIP;
        REG_SNAP_SEC_LO_ADDR: sel = SEL_SNAP_LO;
        REG_SNAP_SEC_HI_ADDR: sel = SEL_SNAP_HI;
        REG_SNAP_NSEC_ADDR:   sel = SEL_SNAP_NSEC;
        REG_SET_SEC_LO_ADDR:  sel = SEL_SET_LO;
        REG_SET_SEC_HI_ADDR:  sel = SEL_SET_HI;
        REG_SET_NSEC_ADDR:    sel = SEL_SET_NSEC;
        REG_CTRL_ADDR:        sel = SEL_CTRL;
        default:              sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rtclock_axi_regs_axil_wr_collect.sv
// axil_wr_collect
// Collects the AXI4-Lite AW and W beats, which may arrive in either order or
// together, into a latch pair with full flags. Issues a single-cycle commit
// when both are available and owns BVALID.
// Ports: clk, rst (async, active-high); awaddr/awvalid/awready;
// wdata/wstrb/wvalid/wready; bready/bvalid; commit with commit_addr,
// commit_data, commit_strb (bypass of the latch when the beat is live).
module axil_wr_collect #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic                    bready,
  output logic                    bvalid,
  output logic                    commit,
  output logic [ADDR_WIDTH-1:0]   commit_addr,
  output logic [DATA_WIDTH-1:0]   commit_data,
  output logic [DATA_WIDTH/8-1:0] commit_strb
);

  logic                    aw_full;
  logic                    w_full;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    aw_hs;
  logic                    w_hs;

  assign awready = !aw_full && !bvalid;
  assign wready  = !w_full && !bvalid;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // Latches stay full through the response phase, so commit needs !bvalid
  // to fire exactly once per transaction.
  assign commit      = (aw_full || aw_hs) && (w_full || w_hs) && !bvalid;
  assign commit_addr = aw_full ? aw_addr : awaddr;
  assign commit_data = w_full ? w_data : wdata;
  assign commit_strb = w_full ? w_strb : wstrb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
    end else if (bvalid && bready) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= awaddr;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (commit) bvalid <= 1'b1;
    end
  end

endmodule

// File: rtl/rtclock_axi_regs.sv
// rtclock_axi_regs
// AXI4-Lite slave holding the rtclock CPU register map: ID/VERSION, the FLIP
// test register, coherent {sec,nsec} snapshots and the set-time staging
// registers with the set_time load strobe.
// Ports: S_AXI_ACLK, S_AXI_ARESET (async, active-high), AXI4-Lite AW/W/B/AR/R
// channels; sec/nsec live time in; set_sec/set_nsec/set_time load interface out.
module rtclock_axi_regs
  import rtclock_axi_regs_pkg::*;
#(
  parameter int unsigned                    C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned                    C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0]  C_BASEADDR         = 32'h00000000,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0]  C_ID               = 32'h52544300,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0]  C_VERSION          = 32'h00010000
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [47:0]                     sec,
  input  logic [29:0]                     nsec,
  output logic [47:0]                     set_sec,
  output logic [29:0]                     set_nsec,
  output logic                            set_time
);

  logic                            commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
  reg_sel_t                        wr_sel;
  reg_sel_t                        rd_sel;
  logic [31:0]                     wr_old;
  logic [31:0]                     wr_merged;
  logic [31:0]                     rd_value;
  logic [1:0]                      rd_resp;
  logic                            ar_hs;

  logic [31:0] flip_q;
  logic [31:0] set_lo_q;
  logic [15:0] set_hi_q;
  logic [29:0] set_nsec_q;
  logic [47:0] shadow_sec;
  logic [29:0] shadow_nsec;

  // Window check uses wrap-around subtraction so a base near the top of the
  // address space cannot overflow.
  function automatic reg_sel_t addr_sel(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
    logic [C_S_AXI_ADDR_WIDTH-1:0] off;
    off = a - C_BASEADDR;
    return decode_offset(off[C_S_AXI_ADDR_WIDTH-1:8] == '0, off[7:0]);
  endfunction

  axil_wr_collect #(
    .ADDR_WIDTH(C_S_AXI_ADDR_WIDTH),
    .DATA_WIDTH(C_S_AXI_DATA_WIDTH)
  ) u_wr_collect (
    .clk        (S_AXI_ACLK),
    .rst        (S_AXI_ARESET),
    .awaddr     (S_AXI_AWADDR),
    .awvalid    (S_AXI_AWVALID),
    .awready    (S_AXI_AWREADY),
    .wdata      (S_AXI_WDATA),
    .wstrb      (S_AXI_WSTRB),
    .wvalid     (S_AXI_WVALID),
    .wready     (S_AXI_WREADY),
    .bready     (S_AXI_BREADY),
    .bvalid     (S_AXI_BVALID),
    .commit     (commit),
    .commit_addr(wr_addr),
    .commit_data(wr_data),
    .commit_strb(wr_strb)
  );

  // Byte-merge the write into the zero-extended current value of the target;
  // CTRL and read-only targets merge into zero, so bit0 of the result is the
  // set_time request.
  always_comb begin
    wr_sel = addr_sel(wr_addr);
    wr_old = '0;
    case (wr_sel)
      SEL_FLIP:     wr_old = flip_q;
      SEL_SET_LO:   wr_old = set_lo_q;
      SEL_SET_HI:   wr_old = {16'h0, set_hi_q};
      SEL_SET_NSEC: wr_old = {2'b0, set_nsec_q};
      default:      wr_old = '0;
    endcase
    wr_merged = merge_bytes(wr_old, wr_data, wr_strb);
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      flip_q      <= FLIP_RESET;
      set_lo_q    <= SET_SEC_RESET;
      set_hi_q    <= SET_SECH_RESET;
      set_nsec_q  <= SET_NSEC_RESET;
      set_time    <= 1'b0;
      S_AXI_BRESP <= RESP_OKAY;
    end else begin
      set_time <= commit && (wr_sel == SEL_CTRL) && wr_merged[0];
      if (commit) begin
        S_AXI_BRESP <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
        case (wr_sel)
          SEL_FLIP:     flip_q     <= wr_merged;
          SEL_SET_LO:   set_lo_q   <= wr_merged;
          SEL_SET_HI:   set_hi_q   <= wr_merged[15:0];
          SEL_SET_NSEC: set_nsec_q <= wr_merged[29:0];
          default:      ;
        endcase
      end
    end
  end

  assign set_sec  = {set_hi_q, set_lo_q};
  assign set_nsec = set_nsec_q;

  assign S_AXI_ARREADY = !S_AXI_RVALID;
  assign ar_hs         = S_AXI_ARVALID && !S_AXI_RVALID;

  always_comb begin
    rd_sel   = addr_sel(S_AXI_ARADDR);
    rd_value = '0;
    rd_resp  = RESP_OKAY;
    case (rd_sel)
      SEL_ID:        rd_value = C_ID;
      SEL_VERSION:   rd_value = C_VERSION;
      SEL_FLIP:      rd_value = ~flip_q;
      SEL_SNAP_LO:   rd_value = sec[31:0];
      SEL_SNAP_HI:   rd_value = {16'h0, shadow_sec[47:32]};
      SEL_SNAP_NSEC: rd_value = {2'b0, shadow_nsec};
      SEL_SET_LO:    rd_value = set_lo_q;
      SEL_SET_HI:    rd_value = {16'h0, set_hi_q};
      SEL_SET_NSEC:  rd_value = {2'b0, set_nsec_q};
      SEL_NONE:      rd_resp  = RESP_SLVERR;
      default:       rd_value = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
      shadow_sec   <= '0;
      shadow_nsec  <= '0;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_value;
      S_AXI_RRESP  <= rd_resp;
      // The snapshot and the returned low word come from the same edge, so
      // later HI/NSEC reads are coherent with this one.
      if (rd_sel == SEL_SNAP_LO) begin
        shadow_sec  <= sec;
        shadow_nsec <= nsec;
      end
    end else if (S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rtclock_axi_regs.sv
// tb_rtclock_axi_regs
// Directed and randomized AXI4-Lite traffic against rtclock_axi_regs, checked
// against a register-map model of the bench plus literal expectations.
module tb_rtclock_axi_regs;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] ID   = 32'h5254_4300;
  localparam logic [31:0] VER  = 32'h0001_0000;
  localparam logic [31:0] STEP = 32'd250_000_001;
  localparam logic [31:0] NS_PER_S = 32'd1_000_000_000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [47:0] sec = '0;
  logic [29:0] nsec = '0;
  logic [47:0] set_sec;
  logic [29:0] set_nsec;
  logic        set_time;

  rtclock_axi_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(32),
    .C_BASEADDR(BASE),
    .C_ID(ID),
    .C_VERSION(VER)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .sec(sec), .nsec(nsec), .set_sec(set_sec), .set_nsec(set_nsec), .set_time(set_time)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- register-map model ----------------
  logic [31:0] m_flip = '0;
  logic [31:0] m_set_lo = '0;
  logic [15:0] m_set_hi = '0;
  logic [29:0] m_set_nsec = '0;
  logic [47:0] m_sh_sec = '0;
  logic [29:0] m_sh_nsec = '0;
  logic        exp_set_time = 1'b0;
  logic        rd_exp_valid = 1'b0;
  logic [31:0] rd_exp_data = '0;
  logic [1:0]  rd_exp_resp = '0;
  logic        mon_en = 1'b0;
  logic        tick_en = 1'b0;
  int          pulse_cnt = 0;
  logic [47:0] pulse_sec = '0;
  logic [29:0] pulse_nsec = '0;

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_flip = '0; m_set_lo = '0; m_set_hi = '0; m_set_nsec = '0;
    m_sh_sec = '0; m_sh_nsec = '0; exp_set_time = 1'b0; rd_exp_valid = 1'b0;
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    logic [31:0] off;
    off = addr - BASE;
    d = '0;
    r = 2'b00;
    if (off >= 32'd256) r = 2'b10;
    else begin
      case (off & 32'hFC)
        32'h00: d = ID;
        32'h04: d = VER;
        32'h08: d = ~m_flip;
        32'h10: begin m_sh_sec = sec; m_sh_nsec = nsec; d = sec[31:0]; end
        32'h14: d = {16'h0, m_sh_sec[47:32]};
        32'h18: d = {2'b0, m_sh_nsec};
        32'h20: d = m_set_lo;
        32'h24: d = {16'h0, m_set_hi};
        32'h28: d = {2'b0, m_set_nsec};
        32'h2C: d = '0;
        default: r = 2'b10;
      endcase
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
    logic [31:0] off;
    logic [31:0] t;
    off = addr - BASE;
    r = 2'b00;
    if (off >= 32'd256) r = 2'b10;
    else begin
      case (off & 32'hFC)
        32'h00, 32'h04, 32'h10, 32'h14, 32'h18: ;
        32'h08: m_flip = bmerge(m_flip, d, s);
        32'h20: m_set_lo = bmerge(m_set_lo, d, s);
        32'h24: begin t = bmerge({16'h0, m_set_hi}, d, s); m_set_hi = t[15:0]; end
        32'h28: begin t = bmerge({2'b0, m_set_nsec}, d, s); m_set_nsec = t[29:0]; end
        32'h2C: if (s[0] && d[0]) exp_set_time = 1'b1;
        default: r = 2'b10;
      endcase
    end
  endtask

  // Live time source: changes just after each rising edge so it is stable at
  // the next one.
  always @(posedge clk) begin
    logic [31:0] t;
    #3;
    if (tick_en) begin
      t = {2'b0, nsec} + STEP;
      if (t >= NS_PER_S) begin
        t = t - NS_PER_S;
        sec = sec + 48'd1;
      end
      nsec = t[29:0];
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      chk("arready", arready, !rvalid);
      chk("rvalid", rvalid, rd_exp_valid);
      if (rvalid) begin
        chk("rdata", rdata, rd_exp_data);
        chk("rresp", rresp, rd_exp_resp);
      end
      if (bvalid) chk("ready_while_bvalid", {awready, wready}, 2'b00);
      chk("set_sec", set_sec, {m_set_hi, m_set_lo});
      chk("set_nsec", set_nsec, m_set_nsec);
      chk("set_time", set_time, exp_set_time);
      if (set_time) begin
        pulse_cnt++;
        pulse_sec = set_sec;
        pulse_nsec = set_nsec;
      end
      exp_set_time = 1'b0;
    end
  end

  task automatic axi_read(input logic [31:0] addr, input int r_dly, output logic [31:0] d,
                          output logic [1:0] r);
    int k;
    logic [31:0] ed;
    logic [1:0] er;
    k = 0;
    @(negedge clk);
    arvalid = 1'b1;
    araddr = addr;
    while (!arready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!arready) begin
      n_checks++; n_fail++;
      $display("FAIL ar_timeout: arready still low after %0d cycles, expected high", k);
      arvalid = 1'b0;
      d = '0; r = '0;
      return;
    end
    model_read(addr, ed, er);
    @(posedge clk);
    rd_exp_data = ed;
    rd_exp_resp = er;
    rd_exp_valid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i < r_dly; i++) @(negedge clk);
    d = rdata;
    r = rresp;
    rready = 1'b1;
    @(posedge clk);
    rd_exp_valid = 1'b0;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] r);
    bit aw_done, w_done, aw_hs, w_hs;
    int k;
    logic [1:0] er;
    aw_done = 0; w_done = 0; k = 0;
    while (!(aw_done && w_done) && k < 40) begin
      @(negedge clk);
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
      if (k == aw_dly) begin awvalid = 1'b1; awaddr = addr; end
      if (k == w_dly) begin wvalid = 1'b1; wdata = d; wstrb = s; end
      chk("bvalid_before_commit", bvalid, 1'b0);
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      @(posedge clk);
      aw_done |= aw_hs;
      w_done |= w_hs;
      k++;
    end
    if (!(aw_done && w_done)) begin
      n_checks++; n_fail++;
      $display("FAIL aw_w_timeout: aw_done=%0d w_done=%0d, expected both 1", aw_done, w_done);
      awvalid = 1'b0; wvalid = 1'b0; r = '0;
      return;
    end
    model_write(addr, d, s, er);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    for (int i = 0; i < b_dly; i++) begin
      chk("bvalid_hold", bvalid, 1'b1);
      chk("bresp_hold", bresp, er);
      @(negedge clk);
    end
    chk("bvalid", bvalid, 1'b1);
    chk("bresp", bresp, er);
    r = bresp;
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_clear", bvalid, 1'b0);
    chk("ready_after_b", {awready, wready}, 2'b11);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] offs [15] = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h18, 32'h20, 32'h24,
                             32'h28, 32'h2C, 32'h0C, 32'h1C, 32'h30, 32'h40, 32'hFC};

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return BASE + 32'h100 + ($urandom & 32'hFF);
    if (sel == 1) return BASE - 32'd4;
    return BASE + (offs[$urandom_range(0, 14)] | 32'($urandom_range(0, 3)));
  endfunction

  initial begin
    logic [31:0] d;
    logic [1:0] r, br;
    int pc;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", {awready, wready, arready}, 3'b111);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_resp", {bresp, rresp}, 4'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_set", {set_time, set_sec, set_nsec}, 79'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    // FLIP basics
    axi_read(BASE + 32'h08, 0, d, r);
    chk("flip_reset", d, 32'hFFFF_FFFF);
    chk("flip_reset_resp", r, 2'b00);
    axi_write(BASE + 32'h08, 32'h1234_5678, 4'hF, 0, 0, 0, br);
    axi_read(BASE + 32'h08, 1, d, r);
    chk("flip_readback", d, 32'hEDCB_A987);

    // W three cycles ahead of AW, BREADY held off for 4 cycles
    axi_write(BASE + 32'h08, 32'h0, 4'hF, 3, 0, 4, br);
    chk("w_early_bresp", br, 2'b00);

    // Byte strobes
    axi_write(BASE + 32'h08, 32'hAABB_CCDD, 4'b0101, 1, 0, 0, br);
    axi_read(BASE + 32'h08, 0, d, r);
    chk("flip_wstrb", d, 32'hFF44_FF22);
    axi_write(BASE + 32'h08, 32'hFFFF_FFFF, 4'b0000, 0, 2, 0, br);
    axi_read(BASE + 32'h08, 0, d, r);
    chk("flip_wstrb0", d, 32'hFF44_FF22);

    // Snapshot coherence
    @(negedge clk);
    sec = 48'h0001_0000_0005;
    nsec = 30'h1000;
    axi_read(BASE + 32'h10, 0, d, r);
    chk("snap_lo", d, 32'h0000_0005);
    tick_en = 1'b1;
    repeat (20) @(negedge clk);
    axi_read(BASE + 32'h14, 0, d, r);
    chk("snap_hi", d, 32'h0000_0001);
    axi_read(BASE + 32'h18, 2, d, r);
    chk("snap_nsec", d, 32'h0000_1000);
    tick_en = 1'b0;

    // Set time
    axi_write(BASE + 32'h20, 32'd7, 4'hF, 0, 0, 0, br);
    axi_write(BASE + 32'h24, 32'd0, 4'hF, 0, 1, 0, br);
    axi_write(BASE + 32'h28, 32'd500, 4'hF, 2, 0, 1, br);
    pc = pulse_cnt;
    axi_write(BASE + 32'h2C, 32'd1, 4'hF, 0, 0, 2, br);
    chk("set_time_pulses", pulse_cnt - pc, 1);
    chk("set_time_sec", pulse_sec, 48'd7);
    chk("set_time_nsec", pulse_nsec, 30'd500);
    axi_read(BASE + 32'h2C, 0, d, r);
    chk("ctrl_read", d, 32'h0);

    // Read-only, unmapped and out-of-window
    axi_read(BASE + 32'h00, 0, d, r);
    chk("id", d, 32'h5254_4300);
    axi_write(BASE + 32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, br);
    chk("ro_write_bresp", br, 2'b00);
    axi_read(BASE + 32'h04, 0, d, r);
    chk("version", d, 32'h0001_0000);
    axi_read(BASE + 32'h40, 0, d, r);
    chk("unmapped_rdata", d, 32'h0);
    chk("unmapped_rresp", r, 2'b10);
    axi_write(BASE + 32'h40, 32'h1111_1111, 4'hF, 0, 0, 0, br);
    chk("unmapped_bresp", br, 2'b10);
    axi_read(32'h0000_0008, 0, d, r);
    chk("below_window_rresp", r, 2'b10);

    // FLIP read accepted on the same edge as a FLIP write commit
    axi_write(BASE + 32'h08, 32'h0F0F_0000, 4'hF, 0, 0, 0, br);
    fork
      axi_write(BASE + 32'h08, 32'h1111_2222, 4'hF, 0, 0, 0, br);
      axi_read(BASE + 32'h08, 0, d, r);
    join
    chk("flip_same_edge", d, 32'hF0F0_FFFF);
    axi_read(BASE + 32'h08, 0, d, r);
    chk("flip_after_same_edge", d, 32'hEEEE_DDDD);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int op;
      logic [31:0] wd, ra, wa;
      logic [1:0]  rr, wr;
      logic [31:0] rd;
      tick_en = $urandom_range(0, 1);
      op = $urandom_range(0, 2);
      wa = rand_addr();
      ra = rand_addr();
      wd = $urandom;
      if (op == 0) begin
        axi_read(ra, $urandom_range(0, 3), rd, rr);
      end else if (op == 1) begin
        axi_write(wa, wd, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), wr);
      end else begin
        fork
          axi_write(wa, wd, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), wr);
          axi_read(ra, $urandom_range(0, 2), rd, rr);
        join
      end
    end
    tick_en = 1'b0;

    // Reset while a read response is pending
    mon_en = 1'b0;
    @(negedge clk);
    arvalid = 1'b1;
    araddr = BASE + 32'h08;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    chk("rvalid_before_reset", rvalid, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rvalid_async_reset", rvalid, 1'b0);
    chk("rdata_async_reset", rdata, 32'h0);
    chk("ready_async_reset", {awready, wready, arready}, 3'b111);
    chk("set_async_reset", {set_time, set_sec, set_nsec}, 79'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    axi_read(BASE + 32'h08, 0, d, r);
    chk("flip_after_reset2", d, 32'hFFFF_FFFF);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
